checkpoint_ctrl: RTL and testbench
==================================

Name: checkpoint_ctrl

Overview:
- Schedules the rename stage's branch checkpoint slots, the per-branch snapshots of map table, free list and ROB allocator.
- Grants a slot to each dispatching branch and keeps slots in program order as a circular queue.
- Frees slots on correct resolution.
- On mispredict, squashes the offending slot and all younger slots, then sequences a multi-cycle restore during which rename is stalled.

Parameters:
NUM_CKPT, 4, number of checkpoint slots (power of two, >=2)
CKPT_WIDTH, 2, slot index width, log2(NUM_CKPT)
RECOVER_CYCLES, 2, cycles spent in RECOVER per mispredict (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
br_dispatch_req  input  1  rename has a branch to dispatch this cycle
br_dispatch_grant  output  1  slot available; allocation occurs when req && grant
br_ckpt_id  output  CKPT_WIDTH  slot granted (equals tail pointer)
ckpt_save  output  1  req && grant; snapshot strobe to map table / free list / ROB allocator
resolve_valid  input  1  a branch resolved this cycle
resolve_id  input  CKPT_WIDTH  slot of the resolving branch
resolve_mispredict  input  1  resolving branch was mispredicted
restore_en  output  1  one-cycle pulse: restore state from restore_id
restore_id  output  CKPT_WIDTH  slot to restore from
rename_stall  output  1  high while in RECOVER
ckpt_count  output  CKPT_WIDTH+1  occupied slots, 0..NUM_CKPT
perf_mispredict_cnt  output  32  accepted mispredicts (optional feature)
perf_full_stall_cnt  output  32  cycles with req && full (optional feature)

Behaviour:
- Reset values (asynchronous): head=0, tail=0, count=0, all valid/resolved bits 0, state=IDLE, recover counter=0.
- Reset values of outputs: restore_en=0, restore_id=0, rename_stall=0, perf counters 0.
- Queue: head = oldest slot, tail = next free slot, count kept as CKPT_WIDTH+1 bits.
  - Full when count==NUM_CKPT; empty when count==0.
  - Pointers wrap modulo NUM_CKPT.
- br_dispatch_grant is combinational: !full && state==IDLE && !(resolve_valid && resolve_mispredict && valid[resolve_id]).
  - Full is taken from the registered count; there is no same-cycle bypass from a freeing resolve.
- On req && grant, at the next edge: valid[tail]=1, resolved[tail]=0, tail++, count++.
- Resolves to a slot with valid=0 are ignored entirely.
- Correct resolve (resolve_valid && !resolve_mispredict && valid[id]) sets resolved[id].
- Head retire: when valid[head] && resolved[head], clear valid[head], head++, count--.
  - At most one retire per cycle.
  - Head retire may coincide with allocation; count then nets to unchanged.
- Accepted mispredict (resolve_valid && resolve_mispredict && valid[id]), at the next edge:
  - Clear valid for slots id through tail-1 (in queue order).
  - Set tail=id; recompute count=(id-head) mod NUM_CKPT.
  - Register restore_id=id; state goes to RECOVER.
  - The head retire is suppressed in that cycle.
- Mispredict of the head slot leaves the queue empty.
- State IDLE -> RECOVER on an accepted mispredict.
  - restore_en=1 during the first RECOVER cycle only.
  - Counter loads RECOVER_CYCLES-1 and decrements each cycle.
- RECOVER -> IDLE when the counter is 0 (RECOVER lasts exactly RECOVER_CYCLES cycles).
  - rename_stall=1 throughout RECOVER.
- In RECOVER, correct resolves and head retires continue.
  - A mispredict on a surviving (older) slot is accepted: squash again, reload restore_id, re-pulse restore_en, restart the counter.
  - Mispredicts on squashed slots are ignored via valid=0.
- Dispatch and mispredict in the same cycle: the mispredict wins and no allocation occurs.
- Correct resolve of the head slot becomes visible as a retire one cycle after the resolve edge.

Optional Feature:
- CKPT_PERF_EN defined:
  - perf_mispredict_cnt increments on each accepted mispredict.
  - perf_full_stall_cnt increments each cycle br_dispatch_req && full.
  - Both are 32-bit, wrap at 2^32, and are cleared by reset.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset, then 4 consecutive br_dispatch_req -> grants with ids 0,1,2,3; ckpt_save each cycle; ckpt_count=4. 5th req -> grant=0; with CKPT_PERF_EN, perf_full_stall_cnt=1.
- Full queue; correct resolve id 2, then id 0 -> slot 0 retires (count=3), slot 1 blocks head; resolve id 1 -> slots 1,2 retire over 2 cycles; count=1.
- Slots 0..3 allocated; mispredict id 1 -> next cycle restore_en=1 with restore_id=1; rename_stall high 2 cycles; tail=1, count=1; next grant id 1.
- During RECOVER, mispredict on squashed id 3 -> ignored. Mispredict on id 0 -> restore_en re-pulses with restore_id=0, stall lasts 2 more cycles, count=0.
- Same cycle br_dispatch_req and mispredict id 0 -> grant=0, no ckpt_save; tail=0 afterward.
- Assert reset while in RECOVER with count=3 -> immediately state=IDLE, restore_en=0, rename_stall=0, count=0; first post-reset grant id 0.

Source files
------------

// File: rtl/checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// checkpoint_ctrl
//
// Purpose:
//   Schedules the rename stage's branch checkpoint slots (per-branch snapshots
//   of map table, free list and ROB allocator). Slots are handed out in
//   program order from a circular queue, freed in order once their branch
//   resolves correctly, and squashed (offending slot plus everything younger)
//   on a mispredict, after which a multi-cycle restore is sequenced while
//   rename is stalled.
//
// Parameters:
//   NUM_CKPT       number of checkpoint slots (power of two, >= 2)
//   CKPT_WIDTH     slot index width, log2(NUM_CKPT)
//   RECOVER_CYCLES cycles spent restoring per mispredict (>= 1)
//
// Ports:
//   clk                 in   rising-edge clock
//   reset               in   asynchronous active-high reset
//   br_dispatch_req     in   rename has a branch to dispatch
//   br_dispatch_grant   out  a slot is available (allocation on req && grant)
//   br_ckpt_id          out  slot granted (tail pointer)
//   ckpt_save           out  snapshot strobe (req && grant)
//   resolve_valid       in   a branch resolved this cycle
//   resolve_id          in   slot of the resolving branch
//   resolve_mispredict  in   the resolving branch was mispredicted
//   restore_en          out  one-cycle pulse: restore state from restore_id
//   restore_id          out  slot to restore from
//   rename_stall        out  high while a restore is in progress
//   ckpt_count          out  occupied slots, 0..NUM_CKPT
//   perf_mispredict_cnt out  accepted mispredicts (CKPT_PERF_EN only)
//   perf_full_stall_cnt out  cycles with req while full (CKPT_PERF_EN only)
//
// Configuration:
//   Define CKPT_PERF_EN to build the two 32-bit performance counters;
//   otherwise both perf ports are tied to zero.
// ---------------------------------------------------------------------------
module checkpoint_ctrl #(
  parameter int NUM_CKPT       = 4,
  parameter int CKPT_WIDTH     = 2,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  br_dispatch_req,
  output logic                  br_dispatch_grant,
  output logic [CKPT_WIDTH-1:0] br_ckpt_id,
  output logic                  ckpt_save,
  input  logic                  resolve_valid,
  input  logic [CKPT_WIDTH-1:0] resolve_id,
  input  logic                  resolve_mispredict,
  output logic                  restore_en,
  output logic [CKPT_WIDTH-1:0] restore_id,
  output logic                  rename_stall,
  output logic [CKPT_WIDTH:0]   ckpt_count,
  output logic [31:0]           perf_mispredict_cnt,
  output logic [31:0]           perf_full_stall_cnt
);

  localparam int RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [RC_W-1:0]     RC_LOAD    = RC_W'(RECOVER_CYCLES - 1);
  localparam logic [CKPT_WIDTH:0] FULL_COUNT = (CKPT_WIDTH+1)'(NUM_CKPT);

  typedef enum logic {
    ST_IDLE,
    ST_RECOVER
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [RC_W-1:0]       r_recover_cnt;
  logic [RC_W-1:0]       w_recover_cnt_next;
  logic                  r_restore_en;
  logic                  w_restore_en_next;
  logic [CKPT_WIDTH-1:0] r_restore_id;
  logic [CKPT_WIDTH-1:0] w_restore_id_next;

  logic [CKPT_WIDTH-1:0] r_head;
  logic [CKPT_WIDTH-1:0] r_tail;
  logic [CKPT_WIDTH:0]   r_count;
  logic [NUM_CKPT-1:0]   r_valid;
  logic [NUM_CKPT-1:0]   r_resolved;
  logic [NUM_CKPT-1:0]   w_valid_next;
  logic [NUM_CKPT-1:0]   w_resolved_next;
  logic [NUM_CKPT-1:0]   w_squash_mask;

  logic                  w_full;
  logic                  w_mispredict;
  logic                  w_correct;
  logic                  w_alloc;
  logic                  w_retire;
  logic [CKPT_WIDTH-1:0] w_misp_offset;

  // Event decode. Resolves that point at an unoccupied slot (already retired
  // or squashed) are dropped here, so nothing downstream needs to filter them.
  // Full is taken from the registered count only: a resolve freeing a slot
  // this cycle does not open the grant until the following cycle.
  assign w_full        = (r_count == FULL_COUNT);
  assign w_mispredict  = resolve_valid && resolve_mispredict && r_valid[resolve_id];
  assign w_correct     = resolve_valid && !resolve_mispredict && r_valid[resolve_id];
  assign w_alloc       = br_dispatch_req && br_dispatch_grant;
  assign w_retire      = r_valid[r_head] && r_resolved[r_head] && !w_mispredict;
  assign w_misp_offset = resolve_id - r_head;

  assign br_dispatch_grant = !w_full && (r_state == ST_IDLE) && !w_mispredict;
  assign br_ckpt_id        = r_tail;
  assign ckpt_save         = w_alloc;
  assign restore_en        = r_restore_en;
  assign restore_id        = r_restore_id;
  assign rename_stall      = (r_state == ST_RECOVER);
  assign ckpt_count        = r_count;

  // Squash mask: a slot is squashed when its age (distance from head, modulo
  // the queue size) is at least that of the mispredicted slot. This covers the
  // mispredicted slot and every younger one, including the wrapped full case
  // where head == tail.
  always_comb begin
    w_squash_mask = '0;
    for (int i = 0; i < NUM_CKPT; i++) begin
      w_squash_mask[i] = ((CKPT_WIDTH'(i) - r_head) >= w_misp_offset);
    end
  end

  // Next-state of the per-slot valid/resolved bits. A mispredict overrides
  // everything else in its cycle: no retire, no allocation (grant is already
  // low), only the squash.
  always_comb begin
    w_valid_next    = r_valid;
    w_resolved_next = r_resolved;
    if (w_mispredict) begin
      w_valid_next = r_valid & ~w_squash_mask;
    end else begin
      if (w_correct) begin
        w_resolved_next[resolve_id] = 1'b1;
      end
      if (w_retire) begin
        w_valid_next[r_head] = 1'b0;
      end
      if (w_alloc) begin
        w_valid_next[r_tail]    = 1'b1;
        w_resolved_next[r_tail] = 1'b0;
      end
    end
  end

  // Queue pointers and occupancy. On a mispredict the tail snaps back to the
  // offending slot and the count becomes its distance from head, which is zero
  // when the head itself mispredicted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_resolved <= '0;
    end else begin
      r_valid    <= w_valid_next;
      r_resolved <= w_resolved_next;
      if (w_mispredict) begin
        r_tail  <= resolve_id;
        r_count <= {1'b0, w_misp_offset};
      end else begin
        if (w_retire) begin
          r_head <= r_head + CKPT_WIDTH'(1);
        end
        if (w_alloc) begin
          r_tail <= r_tail + CKPT_WIDTH'(1);
        end
        if (w_alloc && !w_retire) begin
          r_count <= r_count + (CKPT_WIDTH+1)'(1);
        end else if (!w_alloc && w_retire) begin
          r_count <= r_count - (CKPT_WIDTH+1)'(1);
        end
      end
    end
  end

  // Recovery FSM state register, including the registered restore strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_recover_cnt <= '0;
      r_restore_en  <= 1'b0;
      r_restore_id  <= '0;
    end else begin
      r_state       <= w_state_next;
      r_recover_cnt <= w_recover_cnt_next;
      r_restore_en  <= w_restore_en_next;
      r_restore_id  <= w_restore_id_next;
    end
  end

  // Recovery FSM next-state. Any accepted mispredict (also one arriving in
  // the middle of a restore) restarts the sequence from the top, so the
  // restore strobe re-pulses and the full RECOVER_CYCLES stall is repeated.
  always_comb begin
    w_state_next       = r_state;
    w_recover_cnt_next = r_recover_cnt;
    w_restore_en_next  = 1'b0;
    w_restore_id_next  = r_restore_id;
    if (w_mispredict) begin
      w_state_next       = ST_RECOVER;
      w_recover_cnt_next = RC_LOAD;
      w_restore_en_next  = 1'b1;
      w_restore_id_next  = resolve_id;
    end else if (r_state == ST_RECOVER) begin
      if (r_recover_cnt == '0) begin
        w_state_next = ST_IDLE;
      end else begin
        w_recover_cnt_next = r_recover_cnt - RC_W'(1);
      end
    end
  end

`ifdef CKPT_PERF_EN
  logic [31:0] r_perf_mispredict_cnt;
  logic [31:0] r_perf_full_stall_cnt;

  // Performance counters: accepted mispredicts and cycles where rename wanted
  // a slot but the queue was full. Both wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_mispredict_cnt <= '0;
      r_perf_full_stall_cnt <= '0;
    end else begin
      if (w_mispredict) begin
        r_perf_mispredict_cnt <= r_perf_mispredict_cnt + 32'd1;
      end
      if (br_dispatch_req && w_full) begin
        r_perf_full_stall_cnt <= r_perf_full_stall_cnt + 32'd1;
      end
    end
  end

  assign perf_mispredict_cnt = r_perf_mispredict_cnt;
  assign perf_full_stall_cnt = r_perf_full_stall_cnt;
`else
  assign perf_mispredict_cnt = 32'd0;
  assign perf_full_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// ---------------------------------------------------------------------------
// tb_checkpoint_ctrl
//
// Self-checking bench for checkpoint_ctrl (NUM_CKPT=4, RECOVER_CYCLES=2).
// A table of directed vectors with hand-derived expectations covers the
// allocation, retire, mispredict and recovery corner cases; a hand-written
// sequence covers reset asserted mid-recovery; randomized traffic is then
// checked every cycle against a queue-based reference model.
// Perf counter checks follow CKPT_PERF_EN.
// ---------------------------------------------------------------------------
module tb_checkpoint_ctrl;

  localparam int N  = 4;
  localparam int W  = 2;
  localparam int RC = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          br_dispatch_req;
  logic          br_dispatch_grant;
  logic [W-1:0]  br_ckpt_id;
  logic          ckpt_save;
  logic          resolve_valid;
  logic [W-1:0]  resolve_id;
  logic          resolve_mispredict;
  logic          restore_en;
  logic [W-1:0]  restore_id;
  logic          rename_stall;
  logic [W:0]    ckpt_count;
  logic [31:0]   perf_mispredict_cnt;
  logic [31:0]   perf_full_stall_cnt;

  checkpoint_ctrl #(
    .NUM_CKPT(N),
    .CKPT_WIDTH(W),
    .RECOVER_CYCLES(RC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .br_dispatch_req(br_dispatch_req),
    .br_dispatch_grant(br_dispatch_grant),
    .br_ckpt_id(br_ckpt_id),
    .ckpt_save(ckpt_save),
    .resolve_valid(resolve_valid),
    .resolve_id(resolve_id),
    .resolve_mispredict(resolve_mispredict),
    .restore_en(restore_en),
    .restore_id(restore_id),
    .rename_stall(rename_stall),
    .ckpt_count(ckpt_count),
    .perf_mispredict_cnt(perf_mispredict_cnt),
    .perf_full_stall_cnt(perf_full_stall_cnt)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  int checkCount = 0;
  int errorCount = 0;

  // Reference model: the in-flight branches as an ordered list of slot ids
  // (oldest first) with a resolved flag each, the next slot to hand out,
  // the remaining restore cycles and the registered restore outputs.
  int          mQueue[$];
  bit          mRes[$];
  int          mTail;
  int          mRecRemain;
  bit          mRestoreEn;
  int          mRestoreId;
  int unsigned mPerfMisp;
  int unsigned mPerfFull;

  typedef struct {
    bit rst;
    bit req;
    bit rv;
    int rid;
    bit rmp;
    bit eGrant;
    int eId;
    bit eSave;
    int eCount;
    bit eRen;
    int eRid;
    bit eStall;
  } vec_t;

  vec_t vecs[$];

  // Single comparison point: every check funnels through here.
  task automatic checkEq(input string name, input longint actual, input longint expected);
    checkCount++;
    if (actual != expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int findSlot(input int id);
    foreach (mQueue[k]) begin
      if (mQueue[k] == id) return k;
    end
    return -1;
  endfunction

  function automatic bit modelMisp();
    return resolve_valid && resolve_mispredict && (findSlot(int'(resolve_id)) >= 0);
  endfunction

  function automatic bit modelGrant();
    return (mQueue.size() < N) && (mRecRemain == 0) && !modelMisp();
  endfunction

  task automatic modelReset();
    mQueue.delete();
    mRes.delete();
    mTail      = 0;
    mRecRemain = 0;
    mRestoreEn = 0;
    mRestoreId = 0;
    mPerfMisp  = 0;
    mPerfFull  = 0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic modelUpdate();
    bit misp;
    bit alloc;
    bit retire;
    int k;
    misp   = modelMisp();
    alloc  = br_dispatch_req && modelGrant();
    retire = !misp && (mQueue.size() > 0) && mRes[0];
    if (br_dispatch_req && (mQueue.size() == N)) mPerfFull++;
    if (misp) begin
      k = findSlot(int'(resolve_id));
      while (mQueue.size() > k) begin
        void'(mQueue.pop_back());
        void'(mRes.pop_back());
      end
      mTail      = int'(resolve_id);
      mRestoreEn = 1;
      mRestoreId = int'(resolve_id);
      mRecRemain = RC;
      mPerfMisp++;
    end else begin
      mRestoreEn = 0;
      if (mRecRemain > 0) mRecRemain--;
      if (resolve_valid && !resolve_mispredict) begin
        k = findSlot(int'(resolve_id));
        if (k >= 0) mRes[k] = 1;
      end
      if (retire) begin
        void'(mQueue.pop_front());
        void'(mRes.pop_front());
      end
      if (alloc) begin
        mQueue.push_back(mTail);
        mRes.push_back(1'b0);
        mTail = (mTail + 1) % N;
      end
    end
  endtask

  task automatic compareModel();
    bit g;
    g = modelGrant();
    checkEq("model grant", br_dispatch_grant, g);
    checkEq("model ckpt_id", br_ckpt_id, mTail);
    checkEq("model ckpt_save", ckpt_save, br_dispatch_req && g);
    checkEq("model count", ckpt_count, mQueue.size());
    checkEq("model restore_en", restore_en, mRestoreEn);
    checkEq("model restore_id", restore_id, mRestoreId);
    checkEq("model rename_stall", rename_stall, mRecRemain > 0);
`ifdef CKPT_PERF_EN
    checkEq("model perf_mispredict", perf_mispredict_cnt, mPerfMisp);
    checkEq("model perf_full_stall", perf_full_stall_cnt, mPerfFull);
`else
    checkEq("perf_mispredict tied", perf_mispredict_cnt, 0);
    checkEq("perf_full_stall tied", perf_full_stall_cnt, 0);
`endif
  endtask

  task automatic applyStimulus(input bit req, input bit rv, input int rid, input bit rmp);
    br_dispatch_req    = req;
    resolve_valid      = rv;
    resolve_id         = W'(rid);
    resolve_mispredict = rmp;
  endtask

  // Compare against the hand-written expectation of one table vector.
  task automatic checkOutput(input vec_t v, input int idx);
    checkEq($sformatf("vec%0d grant", idx), br_dispatch_grant, v.eGrant);
    checkEq($sformatf("vec%0d ckpt_id", idx), br_ckpt_id, v.eId);
    checkEq($sformatf("vec%0d ckpt_save", idx), ckpt_save, v.eSave);
    checkEq($sformatf("vec%0d count", idx), ckpt_count, v.eCount);
    checkEq($sformatf("vec%0d restore_en", idx), restore_en, v.eRen);
    checkEq($sformatf("vec%0d restore_id", idx), restore_id, v.eRid);
    checkEq($sformatf("vec%0d rename_stall", idx), rename_stall, v.eStall);
  endtask

  // Inputs are driven 1 unit after a rising edge; outputs are sampled on the
  // falling edge; the model then steps and the bench moves past the next edge.
  task automatic stepCycle();
    @(negedge clk);
    compareModel();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0, 0);
    reset = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic void addVec(input bit rst, input bit req, input bit rv, input int rid,
                                 input bit rmp, input bit g, input int id, input bit s,
                                 input int c, input bit ren, input int rrid, input bit st);
    vec_t v;
    v.rst = rst; v.req = req; v.rv = rv; v.rid = rid; v.rmp = rmp;
    v.eGrant = g; v.eId = id; v.eSave = s; v.eCount = c;
    v.eRen = ren; v.eRid = rrid; v.eStall = st;
    vecs.push_back(v);
  endfunction

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0);
    modelReset();
    #2;
    checkEq("reset count", ckpt_count, 0);
    checkEq("reset restore_en", restore_en, 0);
    checkEq("reset restore_id", restore_id, 0);
    checkEq("reset rename_stall", rename_stall, 0);
    checkEq("reset ckpt_id", br_ckpt_id, 0);
    checkEq("reset perf_mispredict", perf_mispredict_cnt, 0);
    checkEq("reset perf_full_stall", perf_full_stall_cnt, 0);

    // rst req rv rid rmp | grant id save count ren rid stall
    // Fill to full, then a fifth request is refused.
    addVec(1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 2, 1, 2, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 3, 1, 3, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0);
    // Resolve 2 then 0: slot 0 retires, slot 1 blocks; resolve 1 drains 1,2.
    addVec(0, 0, 1, 2, 0,  0, 0, 0, 4, 0, 0, 0);
    addVec(0, 0, 1, 0, 0,  0, 0, 0, 4, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0);
    addVec(0, 0, 1, 1, 0,  1, 0, 0, 3, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,  1, 0, 0, 3, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,  1, 0, 0, 2, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
    // Mispredict 1, squashed 3 ignored, mispredict 0 restarts recovery.
    addVec(1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 2, 1, 2, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 3, 1, 3, 0, 0, 0);
    addVec(0, 0, 1, 1, 1,  0, 0, 0, 4, 0, 0, 0);
    addVec(0, 0, 1, 3, 1,  0, 1, 0, 1, 1, 1, 1);
    addVec(0, 0, 1, 0, 1,  0, 1, 0, 1, 0, 1, 1);
    addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    addVec(0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    // Dispatch and mispredict in the same cycle: mispredict wins.
    addVec(1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    addVec(0, 1, 1, 0, 1,  0, 1, 0, 1, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 1);
    addVec(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
    addVec(0, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    // Mispredict 1 from full, then the next grant reuses slot 1.
    addVec(1, 1, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 2, 1, 2, 0, 0, 0);
    addVec(0, 1, 0, 0, 0,  1, 3, 1, 3, 0, 0, 0);
    addVec(0, 0, 1, 1, 1,  0, 0, 0, 4, 0, 0, 0);
    addVec(0, 0, 0, 0, 0,  0, 1, 0, 1, 1, 1, 1);
    addVec(0, 0, 0, 0, 0,  0, 1, 0, 1, 0, 1, 1);
    addVec(0, 1, 0, 0, 0,  1, 1, 1, 1, 0, 1, 0);
    addVec(0, 1, 0, 0, 0,  1, 2, 1, 2, 0, 1, 0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) doReset();
      applyStimulus(vecs[i].req, vecs[i].rv, vecs[i].rid, vecs[i].rmp);
      @(negedge clk);
      checkOutput(vecs[i], i);
      compareModel();
      modelUpdate();
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a restore with three slots occupied.
    doReset();
    for (int i = 0; i < N; i++) begin
      applyStimulus(1, 0, 0, 0);
      stepCycle();
    end
    applyStimulus(0, 1, 3, 1);
    stepCycle();
    applyStimulus(0, 0, 0, 0);
    #1;
    checkEq("pre-reset restore_en", restore_en, 1);
    checkEq("pre-reset count", ckpt_count, 3);
    checkEq("pre-reset restore_id", restore_id, 3);
    reset = 1'b1;
    #1;
    checkEq("async reset restore_en", restore_en, 0);
    checkEq("async reset rename_stall", rename_stall, 0);
    checkEq("async reset count", ckpt_count, 0);
    checkEq("async reset restore_id", restore_id, 0);
    checkEq("async reset grant", br_dispatch_grant, 1);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(1, 0, 0, 0);
    @(negedge clk);
    checkEq("post-reset grant", br_dispatch_grant, 1);
    checkEq("post-reset ckpt_id", br_ckpt_id, 0);
    checkEq("post-reset ckpt_save", ckpt_save, 1);
    compareModel();
    modelUpdate();
    @(posedge clk);
    #1;

    // Randomized traffic against the reference model.
    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 399) == 0) doReset();
      applyStimulus($urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 45,
                    int'($urandom_range(0, N-1)),
                    $urandom_range(0, 99) < 20);
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, errorCount);
    $finish;
  end

endmodule
